// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: forward-select encoding, multi-cycle FSM
// states, default execute latency and the forwarding priority helper.
package hazard_ctrl_pkg;

  localparam int MUL_LAT_DEFAULT = 3;
  localparam int MD_CNT_W        = 4;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_W  = 2'd1,
    FWD_M  = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // M beats W; a load in M cannot forward yet, and x0 never matches.
  function automatic fwd_sel_e fwd_sel(input logic [4:0] ra, input logic [4:0] rd_m,
                                       input logic [4:0] rd_w, input logic regwrite_m,
                                       input logic memtoreg_m, input logic regwrite_w);
    fwd_sel_e sel;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == ra) && !memtoreg_m) begin
      sel = FWD_M;
    end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == ra)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_counter.sv
// Multi-cycle mul/div occupancy tracker: IDLE/BUSY FSM with a down-counter that
// freezes while the data memory is stalled.
module md_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic hold,
  output logic md_stall
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  // Next-state and counter update; everything freezes while hold is set.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hold) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            state_d = MD_BUSY;
            cnt_d   = MD_CNT_W'(MUL_LAT - 1);
          end else begin
            state_d = MD_IDLE;
            cnt_d   = {MD_CNT_W{1'b0}};
          end
        end
        MD_BUSY: begin
          if (cnt_q == MD_CNT_W'(1)) begin
            state_d = MD_IDLE;
            cnt_d   = {MD_CNT_W{1'b0}};
          end else begin
            state_d = MD_BUSY;
            cnt_d   = cnt_q - MD_CNT_W'(1);
          end
        end
        default: begin
          state_d = MD_IDLE;
          cnt_d   = {MD_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State registers; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= {MD_CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held from the issue cycle until the final execute cycle, when the op may leave E.
  assign md_stall = ((state_q == MD_IDLE) && start) ||
                    ((state_q == MD_BUSY) && (cnt_q != MD_CNT_W'(1)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decode forwarding plus stall/flush generation.
// Define HAZARD_MULDIV_EN to build the multi-cycle mul/div hold tracker.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ra1D,
  input  logic [4:0] ra2D,
  input  logic       branchD,
  input  logic       pcSrcD,
  input  logic [4:0] rdE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       mdstartE,
  input  logic       iwait,
  input  logic       dwait,
  output logic [1:0] forwardaD,
  output logic [1:0] forwardbD,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushW,
  output logic       mdbusy
);

  logic md_stall;
  logic match_e, match_m, lw_stall, br_stall;

`ifdef HAZARD_MULDIV_EN
  md_counter #(.MUL_LAT(MUL_LAT)) u_md_counter (
    .clk      (clk),
    .reset    (reset),
    .start    (mdstartE),
    .hold     (dwait),
    .md_stall (md_stall)
  );
`else
  logic       md_unused;
  logic [3:0] md_lat_unused;
  assign md_unused     = mdstartE ^ clk ^ reset;
  assign md_lat_unused = 4'(MUL_LAT);
  assign md_stall      = 1'b0;
`endif

  assign forwardaD = fwd_sel(ra1D, rdM, rdW, regwriteM, memtoregM, regwriteW);
  assign forwardbD = fwd_sel(ra2D, rdM, rdW, regwriteM, memtoregM, regwriteW);

  // Stall requests are ORed; a stage's flush is dropped whenever that stage is held.
  always_comb begin
    match_e  = (rdE != 5'd0) && ((rdE == ra1D) || (rdE == ra2D));
    match_m  = (rdM != 5'd0) && ((rdM == ra1D) || (rdM == ra2D));
    lw_stall = memtoregE && regwriteE && match_e;
    br_stall = branchD && ((regwriteE && match_e) || (memtoregM && match_m));
    stallD   = dwait || lw_stall || br_stall || md_stall;
    stallF   = stallD || iwait;
    stallE   = dwait || md_stall;
    stallM   = dwait;
    flushE   = (lw_stall || br_stall) && !stallE;
    flushD   = (pcSrcD || iwait) && !stallD;
    flushW   = dwait;
    mdbusy   = md_stall;
  end

endmodule
